// File: rtl/apb_fifo_master_if.sv
// Command/response streams plus the APB3 bus between apb_fifo_master and its slave.
interface apb_fifo_master_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // Bridge side: accepts commands, returns responses, drives the APB request.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  // Environment side: command source, response sink and APB slave.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_fifo_master.sv
// APB3 master: one valid/ready command becomes one APB transfer, with a
// wait-state timeout guarding against a slave that never raises PREADY.
module apb_fifo_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  apb_fifo_master_if.master bus
);

  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state,       state_nxt;
  logic              psel,        psel_nxt;
  logic              penable,     penable_nxt;
  logic              paddr,       paddr_nxt;
  logic              pwrite,      pwrite_nxt;
  logic [DATA_W-1:0] pwdata,      pwdata_nxt;
  logic              rsp_valid,   rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata,   rsp_rdata_nxt;
  logic              rsp_err,     rsp_err_nxt;
  logic              rsp_timeout, rsp_timeout_nxt;
  logic [CNT_W-1:0]  wait_cnt,    wait_cnt_nxt;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(CNT_LAST));

  // State and all registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      paddr       <= paddr_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_nxt       = state;
    psel_nxt        = psel;
    penable_nxt     = penable;
    paddr_nxt       = paddr;
    pwrite_nxt      = pwrite;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    wait_cnt_nxt    = wait_cnt;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_nxt  = bus.cmd_write;
          paddr_nxt   = bus.cmd_addr;
          pwdata_nxt  = bus.cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY || timeout_hit) begin
          if (bus.PREADY) begin
            rsp_rdata_nxt   = pwrite ? '0 : bus.PRDATA;
            rsp_err_nxt     = bus.PSLVERR;
            rsp_timeout_nxt = 1'b0;
          end else begin
            rsp_rdata_nxt   = '0;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
          end
          rsp_valid_nxt = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          paddr_nxt     = 1'b0;
          pwrite_nxt    = 1'b0;
          pwdata_nxt    = '0;
          state_nxt     = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drive the interface; cmd_ready is decoded straight from the state.
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PADDR       = paddr;
  assign bus.PWRITE      = pwrite;
  assign bus.PWDATA      = pwdata;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.rsp_timeout = rsp_timeout;

endmodule
